// File: rtl/mips_cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_if
// Description : Request/result bundle for the MIPS HI/LO multiply-divide unit.
//               The master (pipeline) issues operations and MTHI/MTLO writes.
//               The slave (muldiv unit) returns HI/LO, busy and done.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_cpu_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv
// Description : Iterative MIPS multiply/divide unit owning the HI/LO registers.
//               MULT/MULTU: 32-step shift-add on operand magnitudes.
//               DIV/DIVU  : 32-step restoring division on operand magnitudes.
//               Signs are applied to the magnitude result in the FIN cycle.
//               Build option MIPS_MULDIV_FAST_MULT_EN: multiplies complete
//               with a single-cycle 64-bit product (IDLE -> FIN -> IDLE).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv (
  input  logic                clk,
  input  logic                reset,
  mips_cpu_muldiv_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // op[1] selects divide, op[0] selects unsigned
  localparam logic [4:0] C_LAST_ITER = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [1:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [63:0] acc_q,   acc_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  // Absolute value for signed ops; 32'h80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

  logic        w_op_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_in_signed;
  logic [31:0] w_in_mag_a;
  logic [31:0] w_in_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_next;
  logic        w_res_neg;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic [63:0] w_fast_prod;
`endif

  // Datapath: one iteration step for each algorithm plus final sign fix-up.
  // acc holds the product for multiply, {remainder, quotient} for divide.
  always_comb begin
    w_op_signed = ~op_q[0];
    w_mag_a     = magnitude(a_q, w_op_signed);
    w_mag_b     = magnitude(b_q, w_op_signed);
    w_in_signed = ~bus.op[0];
    w_in_mag_a  = magnitude(bus.a, w_in_signed);
    w_in_mag_b  = magnitude(bus.b, w_in_signed);

    // Shift-add: multiplier bits drain out of the low half, carry enters top.
    w_mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? w_mag_a : 32'd0)};
    w_mul_next = {w_mul_sum, acc_q[31:1]};

    // Restoring divide: shift next dividend bit into the partial remainder.
    w_div_shift = {acc_q[63:32], acc_q[31]};
    w_div_ge    = (w_div_shift >= {1'b0, w_mag_b});
    w_div_diff  = w_div_shift[31:0] - w_mag_b;
    w_div_next  = w_div_ge ? {w_div_diff, acc_q[30:0], 1'b1}
                           : {w_div_shift[31:0], acc_q[30:0], 1'b0};

    w_res_neg = w_op_signed & (a_q[31] ^ b_q[31]);
    w_prod    = w_res_neg ? (~acc_q + 64'd1) : acc_q;
    w_quo     = w_res_neg ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    w_rem     = (w_op_signed & a_q[31]) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    if (!op_q[1]) begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end else if (b_q == 32'd0) begin
      w_res_hi = a_q;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end

`ifdef MIPS_MULDIV_FAST_MULT_EN
    w_fast_prod = {32'd0, w_in_mag_a} * {32'd0, w_in_mag_b};
`endif
  end

  // Next-state: operation sequencing and HI/LO write arbitration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // start takes priority; a coincident MTHI/MTLO is dropped
          op_d  = bus.op;
          a_d   = bus.a;
          b_d   = bus.b;
          cnt_d = 5'd0;
`ifdef MIPS_MULDIV_FAST_MULT_EN
          if (!bus.op[1]) begin
            acc_d   = w_fast_prod;
            state_d = S_FIN;
          end else begin
            acc_d   = {32'd0, w_in_mag_a};
            state_d = S_RUN;
          end
`else
          acc_d   = bus.op[1] ? {32'd0, w_in_mag_a} : {32'd0, w_in_mag_b};
          state_d = S_RUN;
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? w_div_next : w_mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_ITER) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = w_res_hi;
        lo_d    = w_res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_muldiv
// Description : Self-checking bench for mips_cpu_muldiv. A behavioural model
//               (native SV arithmetic, latency countdown) is compared with the
//               DUT every cycle; directed vectors pin known results.
//               Honours MIPS_MULDIV_FAST_MULT_EN for multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_muldiv;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic void compute(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib, iq, ir;
    h = 32'd0;
    l = 32'd0;
    case (op)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        h  = p[63:32];
        l  = p[31:0];
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      2'd2: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0; l = 32'h8000_0000;
        end else begin
          ia = a; ib = b;
          iq = ia / ib;
          ir = ia % ib;
          h  = ir; l = iq;
        end
      end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op);
`ifdef MIPS_MULDIV_FAST_MULT_EN
    return op[1] ? 33 : 1;
`else
    return (op == op) ? 33 : 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Model state and per-cycle comparison, sampled 1 time unit after each edge.
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_busy = 0, m_done = 0;
  int          m_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_cnt = 0;
      end else if (m_busy) begin
        m_done = 1'b0;
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        if (bus.start) begin
          compute(bus.op, bus.a, bus.b, p_hi, p_lo);
          m_cnt  = lat(bus.op);
          m_busy = 1'b1;
        end else begin
          if (bus.hi_we) m_hi = bus.wdata;
          if (bus.lo_we) m_lo = bus.wdata;
        end
      end
      chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic wait_done(input int budget, output int k);
    k = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40, k);
    chk({name, "_latency"}, 32'(k), 32'(lat(op)));
    chk({name, "_hi"}, bus.hi, eh);
    chk({name, "_lo"}, bus.lo, el);
  endtask

  initial begin
    logic [31:0] h, l;
    int          k;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Pin the reference model to hand-computed values.
    compute(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
    chk("pin_multu_hi", h, 32'hFFFF_FFFE); chk("pin_multu_lo", l, 32'h0000_0001);
    compute(2'd0, 32'hFFFF_FFFD, 32'd7, h, l);
    chk("pin_mult_hi", h, 32'hFFFF_FFFF);  chk("pin_mult_lo", l, 32'hFFFF_FFEB);
    compute(2'd2, 32'hFFFF_FFF9, 32'd2, h, l);
    chk("pin_div_hi", h, 32'hFFFF_FFFF);   chk("pin_div_lo", l, 32'hFFFF_FFFD);
    compute(2'd3, 32'd100, 32'd3, h, l);
    chk("pin_divu_hi", h, 32'd1);          chk("pin_divu_lo", l, 32'd33);

    // Directed vectors with literal results.
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("mult_6x7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42);
    run_op("divu_9_4", 2'd3, 32'd9, 32'd4, 32'd1, 32'd2);

    // Start and MTHI while busy are ignored; MTHI after done lands.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd55; bus.b = 32'd66;
    bus.hi_we = 1'b1; bus.wdata = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(40, k);
    chk("busy_ign_latency", 32'(k), 32'd29);
    chk("busy_ign_hi", bus.hi, 32'd1);
    chk("busy_ign_lo", bus.lo, 32'd33);
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'd5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'd5);
    chk("mthi_lo", bus.lo, 32'd33);

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_done(40, k);
    chk("rst_no_done", 32'(k), 32'd0);
    run_op("divu_after_rst", 2'd3, 32'd100, 32'd3, 32'd1, 32'd33);

    // Randomized traffic with idle writes and junk inputs while busy.
    for (int t = 0; t < 80; t++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'($urandom_range(0, 1));
        bus.lo_we = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = pick();
      bus.b     = pick();
      bus.hi_we = ($urandom_range(0, 3) == 0);
      bus.lo_we = ($urandom_range(0, 3) == 0);
      bus.wdata = $urandom;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!bus.busy) break;
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.hi_we = 1'($urandom_range(0, 1));
        bus.lo_we = 1'($urandom_range(0, 1));
        bus.wdata = $urandom;
      end
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
